rom_logo_arbiter: RTL and testbench

Single-port access controller for the 4096×8 logo ROM in the VGA screensaver. It shares the ROM's one combinational read port among three requesters in fixed priority: the display pixel fetch (hard real-time), an auxiliary handshake port, and an optional background checksum scanner. Every read has a fixed one-cycle latency. The block sits between the pixel renderer and the ROM instance.

---
 rtl/rom_logo_pkg.sv | 20 ++
 rtl/rom_logo_checksum.sv | 69 ++++++
 rtl/rom_logo_arbiter.sv | 122 ++++++++++++
 tb/tb_rom_logo_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_logo_pkg.sv
// Shared constants and enums for the logo ROM arbiter and its checksum scanner.
package rom_logo_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int PIX_W  = 6;
  localparam int SUM_W  = 16;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DISP,
    SRC_AUX,
    SRC_SCAN
  } src_t;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_RUN,
    SCAN_DONE
  } scan_state_t;
endpackage

// File: rtl/rom_logo_checksum.sv
// Background checksum scanner: walks every ROM address once and sums the bytes.
// It raises req while it has addresses left; grant marks an issued read, data_vld its result.
module rom_logo_checksum
  import rom_logo_pkg::*;
#(
  parameter int ADDR_W = rom_logo_pkg::ADDR_W,
  parameter int DATA_W = rom_logo_pkg::DATA_W,
  parameter int SUM_W  = rom_logo_pkg::SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  input  logic              grant,
  input  logic              data_vld,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum
);
  scan_state_t       state_d, state_q;
  logic [ADDR_W-1:0] ptr_d, ptr_q;
  logic              issued_d, issued_q;
  logic [SUM_W-1:0]  sum_d, sum_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    issued_d = issued_q;
    sum_d    = sum_q;
    // No read is issued in a start cycle, so nothing stale lands in the cleared sum.
    req      = (state_q == SCAN_RUN) && !issued_q && !start;
    if (start) begin
      state_d  = SCAN_RUN;
      ptr_d    = '0;
      issued_d = 1'b0;
      sum_d    = '0;
    end else if (state_q == SCAN_RUN) begin
      if (grant) begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) issued_d = 1'b1;
      end
      if (data_vld) begin
        sum_d = sum_q + SUM_W'(data);
        if (issued_q) state_d = SCAN_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SCAN_IDLE;
      ptr_q    <= '0;
      issued_q <= 1'b0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      issued_q <= issued_d;
      sum_q    <= sum_d;
    end
  end

  assign addr = ptr_q;
  assign busy = (state_q == SCAN_RUN);
  assign done = (state_q == SCAN_DONE);
  assign sum  = sum_q;
endmodule

// File: rtl/rom_logo_arbiter.sv
// Fixed-priority sharing of the logo ROM read port: display > pending aux > checksum scan.
// Define ROM_SCAN_CHECKSUM_EN to build the background checksum scanner.
module rom_logo_arbiter
  import rom_logo_pkg::*;
#(
  parameter int ADDR_W = rom_logo_pkg::ADDR_W,
  parameter int DATA_W = rom_logo_pkg::DATA_W,
  parameter int PIX_W  = rom_logo_pkg::PIX_W,
  parameter int SUM_W  = rom_logo_pkg::SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [5:0]        disp_x,
  input  logic [5:0]        disp_y,
  output logic              disp_valid,
  output logic [PIX_W-1:0]  disp_q,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_ready,
  output logic              aux_valid,
  output logic [DATA_W-1:0] aux_q,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              scan_done,
  output logic [SUM_W-1:0]  scan_sum,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q
);
  src_t              src_d, src_q;
  logic              pend_valid_d, pend_valid_q;
  logic [ADDR_W-1:0] pend_addr_d, pend_addr_q;
  logic [PIX_W-1:0]  disp_q_d, disp_q_q;
  logic [DATA_W-1:0] aux_q_d, aux_q_q;
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;

`ifdef ROM_SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] scan_data_d, scan_data_q;

  assign scan_data_d = rom_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) scan_data_q <= '0;
    else     scan_data_q <= scan_data_d;
  end

  rom_logo_checksum #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .SUM_W (SUM_W)
  ) u_checksum (
    .clk     (clk),
    .rst     (rst),
    .start   (scan_start),
    .req     (scan_req),
    .addr    (scan_addr),
    .grant   (src_d == SRC_SCAN),
    .data_vld(src_q == SRC_SCAN),
    .data    (scan_data_q),
    .busy    (scan_busy),
    .done    (scan_done),
    .sum     (scan_sum)
  );
`else
  logic unused_scan_start;
  assign unused_scan_start = scan_start;
  assign scan_req  = 1'b0;
  assign scan_addr = '0;
  assign scan_busy = 1'b0;
  assign scan_done = 1'b0;
  assign scan_sum  = '0;
`endif

  always_comb begin
    src_d    = SRC_NONE;
    rom_addr = '0;
    if (disp_req) begin
      src_d    = SRC_DISP;
      rom_addr = ADDR_W'({disp_y, disp_x});
    end else if (pend_valid_q) begin
      src_d    = SRC_AUX;
      rom_addr = pend_addr_q;
    end else if (scan_req) begin
      src_d    = SRC_SCAN;
      rom_addr = scan_addr;
    end

    // Serving the pending entry frees the slot for a same-cycle handshake.
    aux_ready    = !pend_valid_q || (src_d == SRC_AUX);
    pend_valid_d = pend_valid_q && (src_d != SRC_AUX);
    pend_addr_d  = pend_addr_q;
    if (aux_req && aux_ready) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = aux_addr;
    end

    disp_q_d = (src_d == SRC_DISP) ? rom_q[PIX_W-1:0] : disp_q_q;
    aux_q_d  = (src_d == SRC_AUX)  ? rom_q            : aux_q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q        <= SRC_NONE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      disp_q_q     <= '0;
      aux_q_q      <= '0;
    end else begin
      src_q        <= src_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      disp_q_q     <= disp_q_d;
      aux_q_q      <= aux_q_d;
    end
  end

  assign disp_valid = (src_q == SRC_DISP);
  assign aux_valid  = (src_q == SRC_AUX);
  assign disp_q     = disp_q_q;
  assign aux_q      = aux_q_q;
endmodule

// File: tb/tb_rom_logo_arbiter.sv
// Self-checking bench for rom_logo_arbiter: vector table, corner sequences, random traffic vs a queue model.
`timescale 1ns/1ps
module tb_rom_logo_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [5:0]  disp_x, disp_y;
  logic        disp_valid;
  logic [5:0]  disp_q;
  logic        aux_req;
  logic [11:0] aux_addr;
  logic        aux_ready, aux_valid;
  logic [7:0]  aux_q;
  logic        scan_start, scan_busy, scan_done;
  logic [15:0] scan_sum;
  logic [11:0] rom_addr;
  logic [7:0]  rom_q;

  int checks = 0;
  int errors = 0;

  rom_logo_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_valid(disp_valid), .disp_q(disp_q),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_ready(aux_ready),
    .aux_valid(aux_valid), .aux_q(aux_q),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done), .scan_sum(scan_sum),
    .rom_addr(rom_addr), .rom_q(rom_q)
  );

  always #5 clk = ~clk;

  // ROM contents: low byte of the address with the high nibble folded in.
  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], 4'h0};
  endfunction

  assign rom_q = rom_fn(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_req = 1'b0; disp_x = '0; disp_y = '0;
    aux_req = 1'b0; aux_addr = '0; scan_start = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reg_zero(input string tag);
    chk({tag, " disp_valid"}, disp_valid, 0);
    chk({tag, " disp_q"}, disp_q, 0);
    chk({tag, " aux_valid"}, aux_valid, 0);
    chk({tag, " aux_q"}, aux_q, 0);
    chk({tag, " scan_busy"}, scan_busy, 0);
    chk({tag, " scan_done"}, scan_done, 0);
    chk({tag, " scan_sum"}, scan_sum, 0);
    chk({tag, " aux_ready"}, aux_ready, 1);
  endtask

  typedef struct {
    logic        dr;
    logic [5:0]  x, y;
    logic        ar;
    logic [11:0] aa;
    logic [11:0] e_addr;
    logic        e_rdy, e_dv;
    logic [5:0]  e_dq;
    logic        e_av;
    logic [7:0]  e_aq;
  } vec_t;

  function automatic vec_t mk(input int dr, input int x, input int y, input int ar, input int aa,
                              input int ea, input int er, input int edv, input int edq,
                              input int eav, input int eaq);
    vec_t v;
    v.dr = 1'(dr); v.x = 6'(x); v.y = 6'(y); v.ar = 1'(ar); v.aa = 12'(aa);
    v.e_addr = 12'(ea); v.e_rdy = 1'(er); v.e_dv = 1'(edv); v.e_dq = 6'(edq);
    v.e_av = 1'(eav); v.e_aq = 8'(eaq);
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[11];
    logic [11:0] pq[$];
    logic [11:0] hist[20];
    logic [11:0] ga;
    logic [7:0]  b;
    logic [15:0] model_sum;
    logic        exp_dv, exp_av, exp_rdy;
    logic [5:0]  exp_dq;
    logic [7:0]  exp_aq;
    int          kind;
    int          n;

    // rows: drive (dr,x,y,ar,aa) / expect (rom_addr, aux_ready, disp_valid, disp_q, aux_valid, aux_q)
    tbl[0]  = mk(1, 5, 3, 0, 0,         197,    1, 0, 0,  0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0,         0,      1, 1, 5,  0, 0);
    tbl[2]  = mk(1, 63, 63, 1, 'hABC,   'hFFF,  1, 0, 5,  0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,         'hABC,  1, 1, 15, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,         0,      1, 0, 15, 1, 'h1C);
    tbl[5]  = mk(1, 1, 0, 1, 'h123,     1,      1, 0, 15, 0, 'h1C);
    tbl[6]  = mk(1, 2, 0, 1, 'h456,     2,      0, 1, 1,  0, 'h1C);
    tbl[7]  = mk(0, 0, 0, 1, 'h456,     'h123,  1, 1, 2,  0, 'h1C);
    tbl[8]  = mk(0, 0, 0, 0, 0,         'h456,  1, 0, 2,  1, 'h33);
    tbl[9]  = mk(0, 0, 0, 0, 0,         0,      1, 0, 2,  1, 'h16);
    tbl[10] = mk(0, 0, 0, 0, 0,         0,      1, 0, 2,  0, 'h16);

    idle();
    rst = 1'b1;
    #3;
    chk_reg_zero("reset");
    do_reset();

    for (int i = 0; i < 11; i++) begin
      disp_req = tbl[i].dr; disp_x = tbl[i].x; disp_y = tbl[i].y;
      aux_req = tbl[i].ar; aux_addr = tbl[i].aa;
      @(negedge clk);
      chk($sformatf("vec%0d rom_addr", i), rom_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d aux_ready", i), aux_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d disp_valid", i), disp_valid, tbl[i].e_dv);
      chk($sformatf("vec%0d disp_q", i), disp_q, tbl[i].e_dq);
      chk($sformatf("vec%0d aux_valid", i), aux_valid, tbl[i].e_av);
      chk($sformatf("vec%0d aux_q", i), aux_q, tbl[i].e_aq);
      tick();
    end
    idle();

    // Display holds the port for ten cycles while an aux request waits.
    do_reset();
    for (int k = 0; k <= 11; k++) begin
      disp_req = (k <= 9); disp_x = 6'(k); disp_y = 6'd7;
      aux_req = (k == 0); aux_addr = 12'hABC;
      @(negedge clk);
      if (k == 0) chk("prio accept", aux_ready, 1);
      else if (k <= 9) chk($sformatf("prio stall c%0d", k), aux_ready, 0);
      if (k == 10) chk("prio grant addr", rom_addr, 12'hABC);
      if (k == 11) begin
        chk("prio aux_valid", aux_valid, 1);
        chk("prio aux_q", aux_q, rom_fn(12'hABC));
      end else begin
        chk($sformatf("prio no aux_valid c%0d", k), aux_valid, 0);
      end
      tick();
    end
    idle();

    // Aux request every cycle with no display traffic.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      aux_req = 1'b1;
      hist[k] = 12'(k * 37 + 5);
      aux_addr = hist[k];
      @(negedge clk);
      chk($sformatf("aux stream ready c%0d", k), aux_ready, 1);
      if (k >= 2) begin
        chk($sformatf("aux stream valid c%0d", k), aux_valid, 1);
        chk($sformatf("aux stream q c%0d", k), aux_q, rom_fn(hist[k-2]));
      end else begin
        chk($sformatf("aux stream idle c%0d", k), aux_valid, 0);
      end
      tick();
    end
    idle();

    // Random display/aux traffic against a queue-based model.
    do_reset();
    pq.delete();
    exp_dv = 0; exp_dq = 0; exp_av = 0; exp_aq = 0;
    for (int k = 0; k < 400; k++) begin
      disp_req = ($urandom_range(0, 2) == 0);
      disp_x = 6'($urandom); disp_y = 6'($urandom);
      aux_req = $urandom_range(0, 1) == 1;
      aux_addr = 12'($urandom);
      if (disp_req) begin kind = 1; ga = {disp_y, disp_x}; end
      else if (pq.size() != 0) begin kind = 2; ga = pq[0]; end
      else begin kind = 0; ga = '0; end
      exp_rdy = (pq.size() == 0) || (kind == 2);
      @(negedge clk);
      chk($sformatf("rnd%0d rom_addr", k), rom_addr, ga);
      chk($sformatf("rnd%0d aux_ready", k), aux_ready, exp_rdy);
      chk($sformatf("rnd%0d disp_valid", k), disp_valid, exp_dv);
      chk($sformatf("rnd%0d disp_q", k), disp_q, exp_dq);
      chk($sformatf("rnd%0d aux_valid", k), aux_valid, exp_av);
      chk($sformatf("rnd%0d aux_q", k), aux_q, exp_aq);
      b = rom_fn(ga);
      exp_dv = (kind == 1);
      exp_av = (kind == 2);
      if (kind == 1) exp_dq = b[5:0];
      if (kind == 2) begin exp_aq = b; void'(pq.pop_front()); end
      if (aux_req && exp_rdy) pq.push_back(aux_addr);
      tick();
    end
    idle();

    // Asynchronous reset with aux pending (and the scan part-way through when built).
    do_reset();
`ifdef ROM_SCAN_CHECKSUM_EN
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    repeat (1001) tick();
    chk("pre-reset scan_busy", scan_busy, 1);
`endif
    disp_req = 1'b1; disp_x = 6'd9; aux_req = 1'b1; aux_addr = 12'h321;
    tick();
    aux_req = 1'b0;
    tick();
    #1;
    chk("pre-reset aux_ready", aux_ready, 0);
    rst = 1'b1;
    disp_req = 1'b0;
    #1;
    chk_reg_zero("in-reset");
    tick();
    tick();
    chk_reg_zero("held-reset");
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_reg_zero($sformatf("post-reset c%0d", k));
      tick();
    end

    model_sum = '0;
    for (int a = 0; a < 4096; a++) model_sum = model_sum + 16'(rom_fn(12'(a)));

`ifdef ROM_SCAN_CHECKSUM_EN
    // Full scan with display on every other cycle.
    do_reset();
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    n = 0;
    while (!scan_done && n < 20000) begin
      disp_req = (n % 2 == 0);
      disp_x = 6'($urandom); disp_y = 6'($urandom);
      tick();
      n++;
      if (n == 4000) begin
        chk("scan mid busy", scan_busy, 1);
        chk("scan mid done", scan_done, 0);
      end
    end
    idle();
    chk("scan finished in bound", scan_done, 1);
    chk("scan latency window", (n >= 8192 && n <= 8200), 1);
    chk("scan sum", scan_sum, model_sum);
    repeat (5) tick();
    chk("scan done sticky", scan_done, 1);
    chk("scan busy after done", scan_busy, 0);
    chk("scan sum held", scan_sum, model_sum);

    // Restart from DONE, then restart again mid-scan.
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    chk("restart busy", scan_busy, 1);
    chk("restart done cleared", scan_done, 0);
    repeat (500) tick();
    chk("partial sum nonzero", scan_sum != 0, 1);
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    chk("mid restart sum cleared", scan_sum, 0);
    n = 0;
    while (!scan_done && n < 10000) begin
      tick();
      n++;
    end
    chk("restart finished in bound", scan_done, 1);
    chk("restart sum", scan_sum, model_sum);
`else
    do_reset();
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("noscan busy c%0d", k), scan_busy, 0);
      chk($sformatf("noscan done c%0d", k), scan_done, 0);
      chk($sformatf("noscan sum c%0d", k), scan_sum, 0);
      chk($sformatf("noscan rom_addr c%0d", k), rom_addr, 0);
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
